pinball_round_ctrl: RTL and testbench
=====================================

# pinball_round_ctrl

Parametrised game-sequencing core for the pinball table. It generalises the single-player fixed-8-hole round FSM to N holes, N players, configurable ball supply, a roll timeout and saturating per-player scoring. It sits between the debounced/one-pulsed buttons and hole sensors on one side, and the LED, 7-segment, audio and group-select logic on the other.

## Interface
- N_HOLES, 8: number of hole sensors.
- N_PLAYERS, 2: players sharing the table, round-robin.
- BALLS, 8: balls per player per game, 1..15.
- SCORE_W, 15: per-player score width.
- PTS_MATCH, 10: points for a hole inside target_mask.
- PTS_MISS, 1: points for a hole outside target_mask.
- WIN_SCORE, 100: threshold for win flag.
- SETTLE_CYCLES, 200_000_000: dwell after a ball resolves, ≥1.
- ROLL_TIMEOUT, 1_000_000_000: cycles in ROLL before the ball counts as drained, ≥1.
- PW = max(1, $clog2(N_PLAYERS)), derived.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; starts game / returns from OVER.
- launch  in  1  one-cycle pulse; arms a ball.
- hole  in  N_HOLES  hole sensor levels, already synchronised to clk.
- target_mask  in  N_HOLES  scoring holes, sampled on the hit cycle.
- state  out  3  0 IDLE, 1 WAIT, 2 ROLL, 3 SETTLE, 4 OVER.
- player  out  PW  current player.
- balls_left  out  4  balls remaining for current player.
- scores  out  N_PLAYERS*SCORE_W  player p at [p*SCORE_W +: SCORE_W].
- hit_valid  out  1  one-cycle pulse when a ball resolves.
- hit_hole  out  $clog2(N_HOLES)  hole index of last hit; 0 for drain.
- match  out  1  one-cycle pulse, concurrent with hit_valid, hole was in target_mask.
- drained  out  1  one-cycle pulse, concurrent with hit_valid, roll timed out.
- win  out  N_PLAYERS  win[p] = scores[p] ≥ WIN_SCORE; nonzero only in OVER.

## Operation
- Reset: state IDLE, player 0, all scores 0, all ball counters BALLS, hit_hole 0, all pulses 0, win 0, timers 0, hole_d 0.
- IDLE: on start, clear scores, load BALLS into every player, set player 0, go to WAIT. Other inputs are ignored.
- WAIT: on launch, clear the roll timer and go to ROLL. Hole activity is ignored.
- ROLL: rise = hole & ~hole_d. If rise ≠ 0, take the lowest set index i, add PTS_MATCH if target_mask[i] else PTS_MISS to the current player, decrement that player's balls, pulse hit_valid (+match if applicable), and go to SETTLE. If the timer reaches ROLL_TIMEOUT-1 with no rise, add 0 points, decrement balls, pulse hit_valid+drained, and go to SETTLE. A rise on the timeout cycle counts as a hit, not a drain.
- SETTLE: count SETTLE_CYCLES cycles. Then select the next player: scan (player+1)…(player+N_PLAYERS) modulo N_PLAYERS for the first with balls > 0; this wraps to the current player. If one is found, set player and go to WAIT. Otherwise go to OVER.
- OVER: win is valid. On start, go to IDLE. Scores are held until the next start in IDLE clears them.
- Score arithmetic: SCORE_W-bit unsigned, saturating at 2^SCORE_W-1.
- launch in any state other than WAIT and start outside IDLE/OVER are ignored.
- hole_d updates every cycle in all states, so a sensor held high across WAIT→ROLL does not count as a hit.

## Timing
- All outputs are registered.
- Input pulse at edge t → state changes at edge t+1.
- Hit: rise sampled at edge t → at edge t+1 the following are all visible together: state=SETTLE, score, balls_left, hit_hole, hit_valid/match. Pulses deassert at t+2.
- SETTLE entered at edge t → leaves at edge t+SETTLE_CYCLES.
- ROLL entered at edge t with no hits → drained at edge t+ROLL_TIMEOUT.
- balls_left and player update together, so outputs are never torn.
- reset during any state returns to reset values at the next edge, with priority over all inputs.

## Test plan
Parameters for all scenarios: N_HOLES=4, N_PLAYERS=2, BALLS=2, SCORE_W=8, PTS_MATCH=10, PTS_MISS=1, WIN_SCORE=20, SETTLE_CYCLES=4, ROLL_TIMEOUT=16.
- Full game: each player plays 2 balls into hole 1 with mask 0010. Required: scores 20/20, player sequence 0,1,0,1, OVER reached, win=11.
- Simultaneous rise on hole=1010 with mask 1000. Required: hit_hole=1, match=0, +1 point.
- No hole rise for 16 cycles in ROLL. Required: drained pulse, score unchanged, balls_left decremented, SETTLE lasts exactly 4 cycles.
- Hole held high from WAIT into ROLL. Required: no hit. Release and re-assert the hole. Required: a hit on the re-assert.
- Drive a score of 250, then a match. Required: score saturates at 255. launch in SETTLE is ignored, and start in ROLL is ignored.
- reset asserted mid-SETTLE. Required: next cycle shows state 0, scores 0, balls_left 2, and no pulses.

Source files
------------

// File: rtl/pinball_round_ctrl.sv
// Multi-player pinball round sequencer: ball launch, hole/drain resolution,
// saturating per-player scoring, settle dwell and round-robin player rotation.
module pinball_round_ctrl #(
  parameter int N_HOLES       = 8,
  parameter int N_PLAYERS     = 2,
  parameter int BALLS         = 8,
  parameter int SCORE_W       = 15,
  parameter int PTS_MATCH     = 10,
  parameter int PTS_MISS      = 1,
  parameter int WIN_SCORE     = 100,
  parameter int SETTLE_CYCLES = 200_000_000,
  parameter int ROLL_TIMEOUT  = 1_000_000_000,
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1,
  localparam int HW = (N_HOLES > 1) ? $clog2(N_HOLES) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         launch,
  input  logic [N_HOLES-1:0]           hole,
  input  logic [N_HOLES-1:0]           target_mask,
  output logic [2:0]                   state,
  output logic [PW-1:0]                player,
  output logic [3:0]                   balls_left,
  output logic [N_PLAYERS*SCORE_W-1:0] scores,
  output logic                         hit_valid,
  output logic [HW-1:0]                hit_hole,
  output logic                         match,
  output logic                         drained,
  output logic [N_PLAYERS-1:0]         win
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ROLL   = 3'd2,
    S_SETTLE = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t                             r_state, w_state_nx;
  logic [PW-1:0]                      r_player;
  logic [N_PLAYERS-1:0][3:0]          r_balls;
  logic [N_PLAYERS-1:0][SCORE_W-1:0]  r_scores;
  logic [31:0]                        r_timer;
  logic [N_HOLES-1:0]                 r_hole_d;
  logic                               r_hit_valid, r_match, r_drained;
  logic [HW-1:0]                      r_hit_hole;
  logic [N_PLAYERS-1:0]               r_win;

  logic [N_HOLES-1:0]                 w_rise;
  logic [HW-1:0]                      w_idx;
  logic                               w_hit, w_tmo, w_settle_done, w_found;
  logic [PW-1:0]                      w_nxt_player;
  logic [31:0]                        w_pts;
  logic [SCORE_W+31:0]                w_sum;
  logic [SCORE_W-1:0]                 w_sat;
  logic [N_PLAYERS-1:0]               w_win;

  // Scan high-to-low so the lowest rising hole wins a simultaneous rise.
  always_comb begin
    w_rise = hole & ~r_hole_d;
    w_idx  = '0;
    for (int i = N_HOLES - 1; i >= 0; i--)
      if (w_rise[i]) w_idx = HW'(i);
    w_hit         = (r_state == S_ROLL) && (|w_rise);
    w_tmo         = (r_state == S_ROLL) && !w_hit && (r_timer == 32'(ROLL_TIMEOUT - 1));
    w_settle_done = (r_state == S_SETTLE) && (r_timer == 32'(SETTLE_CYCLES - 1));
    w_pts = target_mask[w_idx] ? 32'(PTS_MATCH) : 32'(PTS_MISS);
    w_sum = (SCORE_W+32)'(r_scores[r_player]) + (SCORE_W+32)'(w_pts);
    w_sat = (|w_sum[SCORE_W+31:SCORE_W]) ? '1 : w_sum[SCORE_W-1:0];
  end

  // Next player with balls remaining, starting after the current one and wrapping back to it.
  always_comb begin
    w_found      = 1'b0;
    w_nxt_player = r_player;
    for (int k = 1; k <= N_PLAYERS; k++) begin
      if (!w_found && (r_balls[PW'((int'(r_player) + k) % N_PLAYERS)] != 4'd0)) begin
        w_found      = 1'b1;
        w_nxt_player = PW'((int'(r_player) + k) % N_PLAYERS);
      end
    end
    for (int p = 0; p < N_PLAYERS; p++)
      w_win[p] = (SCORE_W+32)'(r_scores[p]) >= (SCORE_W+32)'(WIN_SCORE);
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nx = S_WAIT;
      S_WAIT:   if (launch) w_state_nx = S_ROLL;
      S_ROLL:   if (w_hit || w_tmo) w_state_nx = S_SETTLE;
      S_SETTLE: if (w_settle_done) w_state_nx = w_found ? S_WAIT : S_OVER;
      S_OVER:   if (start) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_player    <= '0;
      r_scores    <= '0;
      for (int p = 0; p < N_PLAYERS; p++) r_balls[p] <= 4'(BALLS);
      r_timer     <= '0;
      r_hole_d    <= '0;
      r_hit_valid <= 1'b0;
      r_match     <= 1'b0;
      r_drained   <= 1'b0;
      r_hit_hole  <= '0;
      r_win       <= '0;
    end else begin
      r_hole_d    <= hole;
      r_hit_valid <= 1'b0;
      r_match     <= 1'b0;
      r_drained   <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_scores <= '0;
          for (int p = 0; p < N_PLAYERS; p++) r_balls[p] <= 4'(BALLS);
          r_player <= '0;
        end
        S_WAIT: if (launch) r_timer <= '0;
        S_ROLL: begin
          if (w_hit) begin
            r_scores[r_player] <= w_sat;
            r_balls[r_player]  <= r_balls[r_player] - 4'd1;
            r_hit_valid        <= 1'b1;
            r_match            <= target_mask[w_idx];
            r_hit_hole         <= w_idx;
            r_timer            <= '0;
          end else if (w_tmo) begin
            r_balls[r_player]  <= r_balls[r_player] - 4'd1;
            r_hit_valid        <= 1'b1;
            r_drained          <= 1'b1;
            r_hit_hole         <= '0;
            r_timer            <= '0;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        S_SETTLE: begin
          if (w_settle_done) begin
            r_timer <= '0;
            if (w_found) r_player <= w_nxt_player;
            else         r_win    <= w_win;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        S_OVER: if (start) r_win <= '0;
        default: ;
      endcase
    end
  end

  assign state      = r_state;
  assign player     = r_player;
  assign balls_left = r_balls[r_player];
  assign scores     = r_scores;
  assign hit_valid  = r_hit_valid;
  assign hit_hole   = r_hit_hole;
  assign match      = r_match;
  assign drained    = r_drained;
  assign win        = r_win;

endmodule

// File: tb/tb_pinball_round_ctrl.sv
// Bench for pinball_round_ctrl: directed vector table, hand-written game,
// drain and saturation sequences, then random play against an event-level model.
module tb_pinball_round_ctrl;
  localparam int NP = 2, NB = 2, PM = 10, PMS = 1, WS = 20, SC = 4, RT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start = 1'b0, launch = 1'b0;
  logic [3:0] hole = '0, mask = '0;
  logic [2:0] state; logic player; logic [3:0] balls_left; logic [15:0] scores;
  logic hit_valid; logic [1:0] hit_hole; logic match, drained; logic [1:0] win;

  logic start2 = 1'b0, launch2 = 1'b0;
  logic [3:0] hole2 = '0, mask2 = '0;
  logic [2:0] s_state; logic s_player; logic [3:0] s_balls; logic [7:0] s_scores;
  logic s_hv; logic [1:0] s_hh; logic s_match, s_drained; logic s_win;

  pinball_round_ctrl #(.N_HOLES(4), .N_PLAYERS(NP), .BALLS(NB), .SCORE_W(8), .PTS_MATCH(PM),
    .PTS_MISS(PMS), .WIN_SCORE(WS), .SETTLE_CYCLES(SC), .ROLL_TIMEOUT(RT)) dut (
    .clk(clk), .reset(reset), .start(start), .launch(launch), .hole(hole),
    .target_mask(mask), .state(state), .player(player), .balls_left(balls_left),
    .scores(scores), .hit_valid(hit_valid), .hit_hole(hit_hole), .match(match),
    .drained(drained), .win(win));

  // Single-player instance with large match points to reach the saturation boundary.
  pinball_round_ctrl #(.N_HOLES(4), .N_PLAYERS(1), .BALLS(3), .SCORE_W(8), .PTS_MATCH(125),
    .PTS_MISS(1), .WIN_SCORE(WS), .SETTLE_CYCLES(SC), .ROLL_TIMEOUT(RT)) u_sat (
    .clk(clk), .reset(reset), .start(start2), .launch(launch2), .hole(hole2),
    .target_mask(mask2), .state(s_state), .player(s_player), .balls_left(s_balls),
    .scores(s_scores), .hit_valid(s_hv), .hit_hole(s_hh), .match(s_match),
    .drained(s_drained), .win(s_win));

  int n_tests = 0, n_fail = 0;

  // Reference model: tracks game events by edge number rather than by counters.
  int m_state = 0, m_player = 0, m_hh = 0, m_hv = 0, m_match = 0, m_drn = 0;
  int m_edge = 0, m_enter = 0;
  int m_balls[NP], m_scores[NP];
  logic [3:0] m_hole_d = '0;

  task automatic model_step(input logic r, st, ln, input logic [3:0] hl, mk);
    logic [3:0] rise;
    int i, nxt;
    bit found;
    m_edge++;
    if (r) begin
      m_state = 0; m_player = 0; m_hh = 0; m_hv = 0; m_match = 0; m_drn = 0;
      foreach (m_balls[p]) begin m_balls[p] = NB; m_scores[p] = 0; end
      m_hole_d = '0;
      return;
    end
    rise = hl & ~m_hole_d;
    m_hv = 0; m_match = 0; m_drn = 0;
    case (m_state)
      0: if (st) begin
        foreach (m_balls[p]) begin m_balls[p] = NB; m_scores[p] = 0; end
        m_player = 0; m_state = 1;
      end
      1: if (ln) begin m_state = 2; m_enter = m_edge; end
      2: if (rise != 0) begin
        i = 0;
        for (int j = 3; j >= 0; j--) if (rise[j]) i = j;
        m_scores[m_player] += mk[i] ? PM : PMS;
        if (m_scores[m_player] > 255) m_scores[m_player] = 255;
        m_balls[m_player]--;
        m_hv = 1; m_match = mk[i] ? 1 : 0; m_hh = i;
        m_state = 3; m_enter = m_edge;
      end else if (m_edge - m_enter == RT) begin
        m_balls[m_player]--;
        m_hv = 1; m_drn = 1; m_hh = 0;
        m_state = 3; m_enter = m_edge;
      end
      3: if (m_edge - m_enter == SC) begin
        found = 0; nxt = m_player;
        for (int k = 1; k <= NP; k++)
          if (!found && m_balls[(m_player + k) % NP] > 0) begin
            found = 1; nxt = (m_player + k) % NP;
          end
        if (found) begin m_player = nxt; m_state = 1; end
        else m_state = 4;
      end
      4: if (st) m_state = 0;
      default: m_state = 0;
    endcase
    m_hole_d = hl;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, st, ln, input logic [3:0] hl, mk);
    logic [28:0] act, exp;
    logic [1:0] we;
    reset = r; start = st; launch = ln; hole = hl; mask = mk;
    @(posedge clk);
    model_step(r, st, ln, hl, mk);
    #1;
    we = (m_state == 4) ? {m_scores[1] >= WS, m_scores[0] >= WS} : 2'b00;
    exp = {3'(m_state), 1'(m_player), 4'(m_balls[m_player]), 8'(m_scores[1]), 8'(m_scores[0]),
           1'(m_hv), 2'(m_hh), 1'(m_match), 1'(m_drn), we};
    act = {state, player, balls_left, scores, hit_valid, hit_hole, match, drained, win};
    chk("model", 32'(act), 32'(exp));
  endtask

  typedef struct {
    logic r, st, ln; logic [3:0] hl, mk;
    logic [2:0] e_state; logic e_player; logic [3:0] e_balls; logic [15:0] e_scores;
    logic e_hv; logic [1:0] e_hh; logic e_match;
  } vec_t;

  function automatic vec_t mkv(input logic r, st, ln, input logic [3:0] hl, mk,
      input logic [2:0] es, input logic ep, input logic [3:0] eb, input logic [15:0] esc,
      input logic ehv, input logic [1:0] ehh, input logic em);
    vec_t v;
    v.r = r; v.st = st; v.ln = ln; v.hl = hl; v.mk = mk;
    v.e_state = es; v.e_player = ep; v.e_balls = eb; v.e_scores = esc;
    v.e_hv = ehv; v.e_hh = ehh; v.e_match = em;
    return v;
  endfunction

  vec_t tbl[14];
  int sat_exp[3];
  int n;

  initial begin
    // reset, held hole across WAIT->ROLL, simultaneous rise, ignored start/launch, reset mid-SETTLE
    tbl[0]  = mkv(1,0,0,4'h0,4'h0, 3'd0,0,4'd2,16'h0000,0,2'd0,0);
    tbl[1]  = mkv(0,1,0,4'h0,4'h0, 3'd1,0,4'd2,16'h0000,0,2'd0,0);
    tbl[2]  = mkv(0,0,0,4'h2,4'h0, 3'd1,0,4'd2,16'h0000,0,2'd0,0);
    tbl[3]  = mkv(0,0,1,4'h2,4'h0, 3'd2,0,4'd2,16'h0000,0,2'd0,0);
    tbl[4]  = mkv(0,1,0,4'h0,4'h0, 3'd2,0,4'd2,16'h0000,0,2'd0,0);
    tbl[5]  = mkv(0,0,0,4'hA,4'h8, 3'd3,0,4'd1,16'h0001,1,2'd1,0);
    tbl[6]  = mkv(0,1,0,4'hA,4'h8, 3'd3,0,4'd1,16'h0001,0,2'd1,0);
    tbl[7]  = mkv(0,0,0,4'hA,4'h8, 3'd3,0,4'd1,16'h0001,0,2'd1,0);
    tbl[8]  = mkv(0,0,1,4'hA,4'h8, 3'd3,0,4'd1,16'h0001,0,2'd1,0);
    tbl[9]  = mkv(0,0,0,4'hA,4'h8, 3'd1,1,4'd2,16'h0001,0,2'd1,0);
    tbl[10] = mkv(0,0,1,4'hA,4'h0, 3'd2,1,4'd2,16'h0001,0,2'd1,0);
    tbl[11] = mkv(0,1,0,4'hA,4'h0, 3'd2,1,4'd2,16'h0001,0,2'd1,0);
    tbl[12] = mkv(0,0,0,4'h6,4'h4, 3'd3,1,4'd1,16'h0A01,1,2'd2,1);
    tbl[13] = mkv(1,0,0,4'h6,4'h4, 3'd0,0,4'd2,16'h0000,0,2'd0,0);
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].r, tbl[i].st, tbl[i].ln, tbl[i].hl, tbl[i].mk);
      chk($sformatf("vec%0d", i),
          32'({state, player, balls_left, scores, hit_valid, hit_hole, match}),
          32'({tbl[i].e_state, tbl[i].e_player, tbl[i].e_balls, tbl[i].e_scores,
               tbl[i].e_hv, tbl[i].e_hh, tbl[i].e_match}));
    end

    // Full game: four balls into hole 1, all matching.
    cyc(0,1,0,4'h0,4'h2);
    for (int b = 0; b < 4; b++) begin
      cyc(0,0,1,4'h0,4'h2);
      cyc(0,0,0,4'h2,4'h2);
      chk($sformatf("game_player%0d", b), 32'(player), 32'(b % 2));
      chk($sformatf("game_hit%0d", b), 32'({hit_valid, match, hit_hole}), 32'({1'b1, 1'b1, 2'd1}));
      for (int k = 0; k < SC; k++) cyc(0,0,0,4'h0,4'h2);
    end
    chk("game_over", 32'({state, scores, win}), 32'({3'd4, 16'h1414, 2'b11}));
    cyc(0,1,0,4'h0,4'h0);
    chk("over_to_idle", 32'({state, scores, win}), 32'({3'd0, 16'h1414, 2'b00}));
    cyc(0,1,0,4'h0,4'h0);
    chk("restart_clear", 32'({state, scores}), 32'({3'd1, 16'h0000}));

    // Drain after exactly RT edges in ROLL, then SETTLE length.
    cyc(0,0,1,4'h0,4'h0);
    for (int k = 1; k < RT; k++) begin
      cyc(0,0,0,4'h0,4'h0);
      chk("roll_wait", 32'({state, drained, hit_valid}), 32'({3'd2, 1'b0, 1'b0}));
    end
    cyc(0,0,0,4'h0,4'h0);
    chk("drain", 32'({state, hit_valid, drained, match, hit_hole, balls_left, scores}),
        32'({3'd3, 1'b1, 1'b1, 1'b0, 2'd0, 4'd1, 16'h0000}));
    n = 1;
    for (int k = 0; k < 10; k++) begin
      cyc(0,0,0,4'h0,4'h0);
      if (state != 3'd3) break;
      n++;
    end
    chk("settle_len", 32'(n), 32'(SC));
    chk("after_settle", 32'({state, player}), 32'({3'd1, 1'b1}));

    // Saturation on the single-player instance: 125, 250, then clamp at 255.
    sat_exp[0] = 125; sat_exp[1] = 250; sat_exp[2] = 255;
    cyc(1,0,0,4'h0,4'h0);
    start2 = 1'b1; cyc(0,0,0,4'h0,4'h0); start2 = 1'b0;
    chk("sat_wait", 32'(s_state), 32'(1));
    for (int b = 0; b < 3; b++) begin
      launch2 = 1'b1; cyc(0,0,0,4'h0,4'h0); launch2 = 1'b0;
      hole2 = 4'h1; mask2 = 4'h1; cyc(0,0,0,4'h0,4'h0); hole2 = 4'h0;
      chk($sformatf("sat_score%0d", b), 32'({s_hv, s_match, s_scores}), 32'({1'b1, 1'b1, 8'(sat_exp[b])}));
      for (int k = 0; k < SC; k++) cyc(0,0,0,4'h0,4'h0);
    end
    chk("sat_over", 32'({s_state, s_win}), 32'({3'd4, 1'b1}));

    // Random play against the model.
    hole = '0;
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] hl;
      hl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : hole;
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 3) == 0), hl, 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
